// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline-flush control with a stall-buffered redirect and a
// one-cycle exception entry state.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000,
   parameter logic [31:0] EXC_VECTOR   = 32'h80000180
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCIn,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        ExcReq,
   output logic [31:0] Address,
   output logic        FlushIFID,
   output logic        FlushIDEX,
   output logic [31:0] EPC,
   output logic        RedirectPending
);

   typedef enum logic [1:0] {StBoot, StRun, StStalled, StExc} state_e;

   state_e      state_q, state_d;
   logic        pend_q, pend_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] addr;
   logic        flush_ifid, flush_idex;
   logic [31:0] pc_inc;

   assign pc_inc = PCIn + 32'd4;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StBoot;
         pend_q  <= 1'b0;
         tgt_q   <= 32'h0;
         epc_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         tgt_q   <= tgt_d;
         epc_q   <= epc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      tgt_d      = tgt_q;
      epc_d      = epc_q;
      addr       = pc_inc;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      unique case (state_q)
         StBoot: begin
            addr       = RESET_VECTOR;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = StRun;
         end
         StExc: begin
            if (ExcReq) begin
               addr       = EXC_VECTOR;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
               epc_d      = PCIn;
               pend_d     = 1'b0;
               state_d    = StExc;
            end else begin
               addr       = pc_inc;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
               state_d    = StRun;
            end
         end
         default: begin
            // StRun and StStalled share one priority chain; only the buffered
            // redirect release is specific to StStalled.
            if (ExcReq) begin
               addr       = EXC_VECTOR;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
               epc_d      = PCIn;
               pend_d     = 1'b0;
               state_d    = StExc;
            end else if (state_q == StStalled && !Stall && pend_q) begin
               addr       = tgt_q;
               flush_ifid = 1'b1;
               pend_d     = 1'b0;
               state_d    = StRun;
            end else if (Stall) begin
               addr    = PCIn;
               state_d = StStalled;
               if (!pend_q && (BranchTaken || Jump)) begin
                  tgt_d  = BranchTaken ? BranchTarget : JumpTarget;
                  pend_d = 1'b1;
               end
            end else if (BranchTaken) begin
               addr       = BranchTarget;
               flush_ifid = 1'b1;
               state_d    = StRun;
            end else if (Jump) begin
               addr       = JumpTarget;
               flush_ifid = 1'b1;
               state_d    = StRun;
            end else begin
               addr    = pc_inc;
               state_d = StRun;
            end
         end
      endcase
   end

   // Reset overrides combinationally so the PC register loads the vector while held.
   always_comb begin
      if (!Reset) begin
         Address   = {RESET_VECTOR[31:2], 2'b00};
         FlushIFID = 1'b1;
         FlushIDEX = 1'b1;
      end else begin
         Address   = {addr[31:2], 2'b00};
         FlushIFID = flush_ifid;
         FlushIDEX = flush_idex;
      end
   end

   assign EPC             = epc_q;
   assign RedirectPending = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change 1ns after posedge, outputs checked 1ns later.
module tb_pc_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] PCIn;
   logic        Stall;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        ExcReq;
   logic [31:0] Address;
   logic        FlushIFID;
   logic        FlushIDEX;
   logic [31:0] EPC;
   logic        RedirectPending;

   int n_checks = 0;
   int n_fails  = 0;

   pc_sequencer dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .PCIn            (PCIn),
      .Stall           (Stall),
      .BranchTaken     (BranchTaken),
      .BranchTarget    (BranchTarget),
      .Jump            (Jump),
      .JumpTarget      (JumpTarget),
      .ExcReq          (ExcReq),
      .Address         (Address),
      .FlushIFID       (FlushIFID),
      .FlushIDEX       (FlushIDEX),
      .EPC             (EPC),
      .RedirectPending (RedirectPending)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] a, input logic fi, input logic fx);
      chk({tag, ".addr"}, Address, a);
      chk({tag, ".ifid"}, {31'b0, FlushIFID}, {31'b0, fi});
      chk({tag, ".idex"}, {31'b0, FlushIDEX}, {31'b0, fx});
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; PCIn = 32'h1234; Stall = 0; BranchTaken = 0; BranchTarget = 0;
      Jump = 0; JumpTarget = 0; ExcReq = 0;
      #1 Reset = 1'b0;
      #1;
      chk_out("reset", 32'h0, 1'b1, 1'b1);
      chk("reset.rp", {31'b0, RedirectPending}, 32'h0);
      chk("reset.epc", EPC, 32'h0);
      BranchTaken = 1; Stall = 1;
      #1;
      chk_out("reset_ign", 32'h0, 1'b1, 1'b1);
      BranchTaken = 0; Stall = 0;

      // Release between edges; BOOT then sequential fetch with PCIn following Address.
      #4 Reset = 1'b1; PCIn = 32'h0;
      #1;
      chk_out("boot", 32'h0, 1'b1, 1'b1);
      tick(); #1;
      chk_out("seq0", 32'h4, 1'b0, 1'b0);
      tick(); PCIn = 32'h4; #1;
      chk_out("seq1", 32'h8, 1'b0, 1'b0);
      tick(); PCIn = 32'h8; #1;
      chk_out("seq2", 32'hC, 1'b0, 1'b0);

      // Taken branch in RUN.
      tick(); PCIn = 32'h40; BranchTaken = 1; BranchTarget = 32'h100; #1;
      chk_out("br", 32'h100, 1'b1, 1'b0);
      tick(); PCIn = 32'h100; BranchTaken = 0; #1;
      chk_out("br_after", 32'h104, 1'b0, 1'b0);

      // Jump in RUN with misaligned target.
      tick(); PCIn = 32'h10; Jump = 1; JumpTarget = 32'h207; #1;
      chk_out("jmp", 32'h204, 1'b1, 1'b0);

      // Redirect buffered behind a 3-cycle stall; first target wins.
      tick(); PCIn = 32'h20; Stall = 1; Jump = 1; JumpTarget = 32'h200; #1;
      chk_out("st1", 32'h20, 1'b0, 1'b0);
      chk("st1.rp", {31'b0, RedirectPending}, 32'h0);
      tick(); Jump = 0; BranchTaken = 1; BranchTarget = 32'h300; #1;
      chk_out("st2", 32'h20, 1'b0, 1'b0);
      chk("st2.rp", {31'b0, RedirectPending}, 32'h1);
      tick(); BranchTaken = 0; #1;
      chk_out("st3", 32'h20, 1'b0, 1'b0);
      chk("st3.rp", {31'b0, RedirectPending}, 32'h1);
      tick(); Stall = 0; #1;
      chk_out("st_rel", 32'h200, 1'b1, 1'b0);
      tick(); PCIn = 32'h200; #1;
      chk("st_rel.rp", {31'b0, RedirectPending}, 32'h0);
      chk_out("st_after", 32'h204, 1'b0, 1'b0);

      // Stall without redirect, then release with no pending: jump acts as in RUN.
      tick(); PCIn = 32'h50; Stall = 1; #1;
      chk_out("st_plain", 32'h50, 1'b0, 1'b0);
      tick(); Stall = 0; Jump = 1; JumpTarget = 32'h400; #1;
      chk_out("st_nopend", 32'h400, 1'b1, 1'b0);
      chk("st_nopend.rp", {31'b0, RedirectPending}, 32'h0);

      // Exception overrides branch and stall.
      tick(); Jump = 0; PCIn = 32'h60; ExcReq = 1; BranchTaken = 1; Stall = 1; #1;
      chk_out("exc", 32'h80000180, 1'b1, 1'b1);
      tick(); ExcReq = 0; BranchTaken = 0; Stall = 0; PCIn = 32'h80000180; #1;
      chk("exc.epc", EPC, 32'h60);
      chk_out("exc_state", 32'h80000184, 1'b1, 1'b1);
      tick(); PCIn = 32'h80000184; #1;
      chk_out("exc_run", 32'h80000188, 1'b0, 1'b0);
      // Nested exception from EXC updates EPC.
      tick(); PCIn = 32'h70; ExcReq = 1; #1;
      chk_out("exc2", 32'h80000180, 1'b1, 1'b1);
      tick(); PCIn = 32'h80000180; #1;
      chk("exc2.epc", EPC, 32'h70);
      chk_out("exc2_reenter", 32'h80000180, 1'b1, 1'b1);
      tick(); ExcReq = 0; #1;
      chk("exc3.epc", EPC, 32'h80000180);
      chk_out("exc3_state", 32'h80000184, 1'b1, 1'b1);

      // Wrap and target alignment.
      tick(); PCIn = 32'hFFFFFFFC; #1;
      chk_out("wrap", 32'h0, 1'b0, 1'b0);
      tick(); BranchTaken = 1; BranchTarget = 32'h103; #1;
      chk_out("align", 32'h100, 1'b1, 1'b0);

      // Reset in STALLED with a pending redirect.
      tick(); BranchTaken = 1; BranchTarget = 32'h500; Stall = 1; PCIn = 32'h30; #1;
      chk_out("pre_rst", 32'h30, 1'b0, 1'b0);
      tick(); BranchTaken = 0; #1;
      chk("pre_rst.rp", {31'b0, RedirectPending}, 32'h1);
      Reset = 1'b0; #1;
      chk_out("mid_rst", 32'h0, 1'b1, 1'b1);
      chk("mid_rst.rp", {31'b0, RedirectPending}, 32'h0);
      chk("mid_rst.epc", EPC, 32'h0);
      Stall = 0; #1 Reset = 1'b1; #1;
      chk_out("reboot", 32'h0, 1'b1, 1'b1);
      tick(); #1;
      chk_out("reboot_run", 32'h34, 1'b0, 1'b0);
      chk("reboot.rp", {31'b0, RedirectPending}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
